// File: rtl/wbuf_stream_reader_pkg.sv
// Shared types and helpers for the weight-buffer stream reader and the preload controller.
package wbuf_stream_reader_pkg;

   localparam int unsigned COUNT_W = 17;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Requested word count clamped to the buffer depth; zero means a single word.
   function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] cnt,
                                                      input int unsigned       addr_w);
      logic [COUNT_W-1:0] depth;
      depth = COUNT_W'(1) << addr_w;
      if (cnt == '0) begin
         return COUNT_W'(1);
      end else if (cnt > depth) begin
         return depth;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/wbuf_sdp_ram.sv
// Simple dual-port weight RAM: one write port, one read-first registered read port, no reset.
module wbuf_sdp_ram #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 128
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // A read and write to the same address in one cycle returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/wbuf_stream_reader.sv
// Weight-buffer reader: stores DMA preload words and streams a contiguous run
// to the compute array over valid/ready on a level req/done handshake.
module wbuf_stream_reader
   import wbuf_stream_reader_pkg::*;
#(
   parameter int unsigned BUF_ADDR_W = 16,
   parameter int unsigned DATA_W     = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dma_wr_en,
   input  logic [BUF_ADDR_W-1:0] dma_wr_addr,
   input  logic [DATA_W-1:0]     dma_wr_data,
   input  logic                  rd_req,
   input  logic [BUF_ADDR_W-1:0] rd_base,
   input  logic [COUNT_W-1:0]    rd_count,
   output logic                  rd_done,
   output logic                  busy,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [DATA_W-1:0]     w_data,
   output logic                  w_last
);

   state_t                state;
   logic [BUF_ADDR_W-1:0] base_q;
   logic [COUNT_W-1:0]    count_q;
   logic [COUNT_W-1:0]    issued_q;
   logic                  issue_ok_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  tail_valid_q;
   logic                  tail_last_q;
   logic [DATA_W-1:0]     tail_data_q;
   logic [DATA_W-1:0]     ram_rdata;

   logic                  pop_c;
   logic                  issue_c;
   logic                  issue_last_c;
   logic [1:0]            pending_c;
   logic [BUF_ADDR_W-1:0] rd_addr_c;

   // Issue only while the FIFO plus the word in flight leaves room after this cycle's pop.
   always_comb begin
      pop_c        = w_valid & w_ready;
      pending_c    = {1'b0, w_valid} + {1'b0, tail_valid_q} + {1'b0, inflight_q} - {1'b0, pop_c};
      issue_c      = (state == S_RUN) && issue_ok_q && (issued_q < count_q) && (pending_c < 2'd2);
      issue_last_c = (issued_q == count_q - COUNT_W'(1));
      rd_addr_c    = base_q + BUF_ADDR_W'(issued_q);
   end

   wbuf_sdp_ram #(
      .ADDR_W (BUF_ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (dma_wr_en),
      .wr_addr (dma_wr_addr),
      .wr_data (dma_wr_data),
      .rd_en   (issue_c),
      .rd_addr (rd_addr_c),
      .rd_data (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         rd_done         <= 1'b0;
         busy            <= 1'b0;
         base_q          <= '0;
         count_q         <= '0;
         issued_q        <= '0;
         issue_ok_q      <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         w_valid         <= 1'b0;
         w_data          <= '0;
         w_last          <= 1'b0;
         tail_valid_q    <= 1'b0;
         tail_data_q     <= '0;
         tail_last_q     <= 1'b0;
      end else begin
         if (issue_c) begin
            issued_q        <= issued_q + COUNT_W'(1);
            inflight_last_q <= issue_last_c;
         end
         inflight_q <= issue_c;

         // Two-entry FIFO: head drives the stream outputs, tail catches a push behind a stalled head.
         if (!w_valid || pop_c) begin
            if (tail_valid_q) begin
               w_valid      <= 1'b1;
               w_data       <= tail_data_q;
               w_last       <= tail_last_q;
               tail_valid_q <= inflight_q;
               if (inflight_q) begin
                  tail_data_q <= ram_rdata;
                  tail_last_q <= inflight_last_q;
               end
            end else begin
               w_valid <= inflight_q;
               w_last  <= inflight_q & inflight_last_q;
               if (inflight_q) begin
                  w_data <= ram_rdata;
               end
            end
         end else if (inflight_q) begin
            tail_valid_q <= 1'b1;
            tail_data_q  <= ram_rdata;
            tail_last_q  <= inflight_last_q;
         end

         case (state)
            S_IDLE: begin
               if (rd_req) begin
                  state    <= S_RUN;
                  busy     <= 1'b1;
                  base_q   <= rd_base;
                  count_q  <= clamp_count(rd_count, BUF_ADDR_W);
                  issued_q <= '0;
               end
            end
            S_RUN: begin
               // First RAM read goes out the cycle after busy rises.
               issue_ok_q <= 1'b1;
               if (pop_c && w_last) begin
                  state      <= S_DONE;
                  busy       <= 1'b0;
                  rd_done    <= 1'b1;
                  issue_ok_q <= 1'b0;
               end
            end
            S_DONE: begin
               if (!rd_req) begin
                  state   <= S_IDLE;
                  rd_done <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wbuf_stream_reader.sv
// Self-checking bench for wbuf_stream_reader: a memory/queue model of each run
// checked beat by beat, plus literal latency and value pins.
module tb_wbuf_stream_reader;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         dma_wr_en;
   logic [15:0]  dma_wr_addr;
   logic [127:0] dma_wr_data;
   logic         rd_req;
   logic [15:0]  rd_base;
   logic [16:0]  rd_count;
   logic         rd_done;
   logic         busy;
   logic         w_valid;
   logic         w_ready;
   logic [127:0] w_data;
   logic         w_last;

   typedef struct {
      logic [127:0] data;
      logic         known;
      logic         last;
   } beat_t;

   beat_t        exp_q[$];
   logic [127:0] mem_model [int];
   int           n_total = 0;
   int           n_pass  = 0;
   int           hs_count = 0;
   logic [0:5]   bp_pat = 6'b100101;

   wbuf_stream_reader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dma_wr_en   (dma_wr_en),
      .dma_wr_addr (dma_wr_addr),
      .dma_wr_data (dma_wr_data),
      .rd_req      (rd_req),
      .rd_base     (rd_base),
      .rd_count    (rd_count),
      .rd_done     (rd_done),
      .busy        (busy),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .w_data      (w_data),
      .w_last      (w_last)
   );

   always #5 clk = ~clk;

   task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0b expected %0b", name, act, exp);
      else n_pass++;
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else n_pass++;
   endtask

   // Expected beats straight from the run rules: clamped count, wrapped addresses, last on final beat.
   function automatic void build_expect(input int base, input int cnt);
      int    eff;
      int    a;
      beat_t b;
      eff = (cnt == 0) ? 1 : ((cnt > 65536) ? 65536 : cnt);
      for (int i = 0; i < eff; i++) begin
         a       = (base + i) % 65536;
         b.known = mem_model.exists(a);
         b.data  = b.known ? mem_model[a] : '0;
         b.last  = (i == eff - 1);
         exp_q.push_back(b);
      end
   endfunction

   // Per-cycle stream checker.
   initial begin
      beat_t        b;
      logic         stall_q = 1'b0;
      logic         done_due = 1'b0;
      logic [127:0] stall_data = '0;
      logic         stall_last = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_q  = 1'b0;
            done_due = 1'b0;
         end else begin
            if (done_due) begin
               chk_b("rd_done_after_last", rd_done, 1'b1);
               done_due = 1'b0;
            end
            if (stall_q) begin
               chk_b("stall_valid", w_valid, 1'b1);
               chk_w("stall_data", w_data, stall_data);
               chk_b("stall_last", w_last, stall_last);
            end
            if (w_valid && w_ready) begin
               chk_b("beat_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  b = exp_q.pop_front();
                  if (b.known) chk_w("w_data", w_data, b.data);
                  chk_b("w_last", w_last, b.last);
               end
               hs_count++;
               if (w_last) begin
                  chk_b("rd_done_before_last", rd_done, 1'b0);
                  done_due = 1'b1;
               end
            end
            stall_q    = w_valid && !w_ready;
            stall_data = w_data;
            stall_last = w_last;
         end
      end
   end

   task automatic dma_write(input int addr, input logic [127:0] data);
      dma_wr_en   = 1'b1;
      dma_wr_addr = 16'(addr);
      dma_wr_data = data;
      @(posedge clk); #1;
      dma_wr_en = 1'b0;
      mem_model[addr] = data;
   endtask

   // One full run; entered and left 1 time unit after a rising edge.
   task automatic do_run(input int base, input int cnt, input bit bp, input bit coll,
                         input int hold, input int exp_beats, input logic [127:0] first_word);
      int budget;
      int ptr;
      int start_hs;
      build_expect(base, cnt);
      chk_i("model_beats", exp_q.size(), exp_beats);
      start_hs = hs_count;
      rd_base  = 16'(base);
      rd_count = 17'(cnt);
      rd_req   = 1'b1;
      w_ready  = 1'b1;
      @(posedge clk); #1;
      chk_b("busy_e0", busy, 1'b1);
      chk_b("valid_e0", w_valid, 1'b0);
      @(posedge clk); #1;
      chk_b("valid_e1", w_valid, 1'b0);
      if (coll) begin
         dma_wr_en   = 1'b1;
         dma_wr_addr = 16'(base);
         dma_wr_data = 128'hAA;
      end
      @(posedge clk); #1;
      if (coll) begin
         dma_wr_en = 1'b0;
         mem_model[base] = 128'hAA;
      end
      chk_b("valid_e2", w_valid, 1'b0);
      @(posedge clk); #1;
      chk_b("valid_e3", w_valid, 1'b1);
      chk_w("first_word", w_data, first_word);
      ptr    = 0;
      budget = 0;
      while (!rd_done && budget < 70000) begin
         w_ready = bp ? bp_pat[ptr % 6] : 1'b1;
         ptr++;
         @(posedge clk); #1;
         budget++;
      end
      chk_b("run_in_budget", budget < 70000, 1'b1);
      chk_i("beats_seen", hs_count - start_hs, exp_beats);
      chk_i("queue_drained", exp_q.size(), 0);
      chk_b("busy_after_run", busy, 1'b0);
      w_ready = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk_b("hold_done", rd_done, 1'b1);
         chk_b("hold_no_rerun", busy, 1'b0);
         chk_b("hold_no_valid", w_valid, 1'b0);
      end
      rd_req = 1'b0;
      @(posedge clk); #1;
      chk_b("done_falls", rd_done, 1'b0);
      exp_q.delete();
   endtask

   initial begin
      int start_hs;
      int budget;
      rst_n       = 1'b0;
      dma_wr_en   = 1'b0;
      dma_wr_addr = '0;
      dma_wr_data = '0;
      rd_req      = 1'b0;
      rd_base     = '0;
      rd_count    = '0;
      w_ready     = 1'b0;
      #12;
      chk_b("reset_rd_done", rd_done, 1'b0);
      chk_b("reset_busy", busy, 1'b0);
      chk_b("reset_w_valid", w_valid, 1'b0);
      chk_b("reset_w_last", w_last, 1'b0);
      chk_w("reset_w_data", w_data, 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) dma_write(i, 128'(17 * i));
      dma_write(65534, 128'hE0E);
      dma_write(65535, 128'hF0F);

      do_run(0, 8, 1'b0, 1'b0, 0, 8, 128'h00);        // basic
      do_run(0, 8, 1'b1, 1'b0, 0, 8, 128'h00);        // backpressure
      do_run(3, 0, 1'b0, 1'b0, 0, 1, 128'h33);        // zero count -> one word
      do_run(65534, 4, 1'b1, 1'b0, 0, 4, 128'hE0E);   // wrap 65534,65535,0,1
      do_run(5, 3, 1'b0, 1'b1, 0, 3, 128'h55);        // collision: old word streamed
      do_run(5, 1, 1'b0, 1'b0, 0, 1, 128'hAA);        // then the new word
      do_run(6, 2, 1'b0, 1'b0, 5, 2, 128'h66);        // req held after done

      // Reset in the middle of a run.
      build_expect(0, 8);
      start_hs = hs_count;
      rd_base  = 16'd0;
      rd_count = 17'd8;
      rd_req   = 1'b1;
      w_ready  = 1'b1;
      budget   = 0;
      while (hs_count - start_hs < 3 && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      chk_i("beats_before_reset", hs_count - start_hs, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_b("midrun_rst_valid", w_valid, 1'b0);
      chk_b("midrun_rst_busy", busy, 1'b0);
      chk_b("midrun_rst_done", rd_done, 1'b0);
      chk_b("midrun_rst_last", w_last, 1'b0);
      chk_w("midrun_rst_data", w_data, 128'h0);
      rd_req = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk_b("no_resume_valid", w_valid, 1'b0);
         chk_b("no_resume_busy", busy, 1'b0);
      end
      do_run(0, 8, 1'b0, 1'b0, 0, 8, 128'h00);        // fresh run restarts at base

      do_run(0, 70000, 1'b0, 1'b0, 0, 65536, 128'h00); // clamp to depth

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
